// File: rtl/rsv_pkg.sv
// ---------------------------------------------------------------------------
// rsv_pkg -- shared definitions for the rsv instruction-fetch slice.
//   XLEN             : architectural data/address width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_entry_t    : one instruction-buffer entry {pc, inst}
// ---------------------------------------------------------------------------
package rsv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/rsv_fifo.sv
// ---------------------------------------------------------------------------
// rsv_fifo -- generic synchronous FIFO with flush and occupancy count.
//   clk, reset : clock, asynchronous active-high reset
//   flush_i    : drop all entries at the next edge (wins over push/pop)
//   push_i     : write wdata_i (accepted when not full, or full with a pop)
//   wdata_i    : write data
//   pop_i      : remove the head entry (ignored when empty)
//   rdata_o    : head entry (only meaningful when count_o != 0)
//   count_o    : number of stored entries, 0..DEPTH
// DEPTH need not be a power of two; pointers wrap explicitly.
// ---------------------------------------------------------------------------
module rsv_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != FULL_CNT) | do_pop);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by count_q,
    // so stale contents are never observed and the RAM stays reset-free.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/rsv_fetch_buf.sv
// ---------------------------------------------------------------------------
// rsv_fetch_buf -- instruction fetch unit with in-order memory interface and
// a small instruction buffer.
//   clk, reset          : clock, asynchronous active-high reset
//   redirect_i          : start a new fetch stream at redirect_pc_i
//   redirect_pc_i       : redirect target (bits [1:0] ignored)
//   fetch_mem_req_o     : read request, held until granted or redirected
//   fetch_mem_addr_o    : word-aligned request address (the fetch PC)
//   fetch_mem_gnt_i     : memory accepts the current request
//   mem_rvalid_i        : in-order read data valid
//   mem_rd_inst_i       : read data
//   inst_valid_o        : buffer head valid
//   inst_o, inst_pc_o   : head instruction and its address (0 when empty)
//   inst_ready_i        : consumer takes the head
// Requests are issued only against free buffer slots, so the buffer cannot
// overflow. Responses still in flight at a redirect are counted in drop_q
// and discarded on return.
// ---------------------------------------------------------------------------
module rsv_fetch_buf
    import rsv_pkg::*;
#(
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            fetch_mem_req_o,
    output logic [XLEN-1:0] fetch_mem_addr_o,
    input  logic            fetch_mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rd_inst_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
);

    localparam int BUF_CW = $clog2(DEPTH + 1);
    localparam int OUT_CW = $clog2(MAX_OUTST + 1);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [OUT_CW-1:0] drop_q, drop_d;
    logic [OUT_CW-1:0] outst;
    logic [BUF_CW-1:0] buf_count;
    logic [XLEN-1:0]   pend_addr;
    fetch_entry_t      buf_wdata, buf_head;
    logic              grant, rsp_drop, rsp_accept, inst_pop;
    logic              out_credit, buf_credit;

    // Dropped responses still occupy the memory pipeline, so they count
    // against the outstanding limit but not against buffer space.
    assign out_credit = (int'(outst) + int'(drop_q)) < MAX_OUTST;
    assign buf_credit = (int'(buf_count) + int'(outst)) < DEPTH;

    assign fetch_mem_req_o  = ~reset & ~redirect_i & out_credit & buf_credit;
    assign fetch_mem_addr_o = pc_q;

    assign grant      = fetch_mem_req_o & fetch_mem_gnt_i;
    assign rsp_drop   = mem_rvalid_i & (drop_q != '0);
    // A response with nothing pending is a protocol error and is ignored.
    assign rsp_accept = mem_rvalid_i & (drop_q == '0) & (outst != '0);
    assign inst_pop   = inst_valid_o & inst_ready_i;

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_i) begin
            pc_d   = {redirect_pc_i[XLEN-1:2], 2'b00};
            // Everything still in flight, minus what returns this cycle.
            drop_d = drop_q - OUT_CW'(rsp_drop) + outst - OUT_CW'(rsp_accept);
        end else begin
            if (grant)    pc_d   = pc_q + 32'd4;
            if (rsp_drop) drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    // Addresses of granted, not yet returned, requests; its occupancy is
    // the outstanding-request count.
    rsv_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTST)
    ) u_pend_q (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_i),
        .push_i  (grant),
        .wdata_i (pc_q),
        .pop_i   (rsp_accept),
        .rdata_o (pend_addr),
        .count_o (outst)
    );

    assign buf_wdata = '{pc: pend_addr, inst: mem_rd_inst_i};

    rsv_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_i),
        .push_i  (rsp_accept),
        .wdata_i (buf_wdata),
        .pop_i   (inst_pop),
        .rdata_o (buf_head),
        .count_o (buf_count)
    );

    assign inst_valid_o = (buf_count != '0);
    assign inst_o       = inst_valid_o ? buf_head.inst : '0;
    assign inst_pc_o    = inst_valid_o ? buf_head.pc   : '0;

`ifndef SYNTHESIS
    a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (reset)
        !(mem_rvalid_i && (outst == '0) && (drop_q == '0)));
`endif

endmodule

// File: tb/tb_rsv_fetch_buf.sv
// ---------------------------------------------------------------------------
// tb_rsv_fetch_buf -- self-checking bench for rsv_fetch_buf.
// Directed table, hand-written corner sequences and a randomized run, all
// compared against a queue-based reference model of the fetch unit.
// ---------------------------------------------------------------------------
module tb_rsv_fetch_buf;
    import rsv_pkg::*;

    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RST_PC    = 32'h0000_0000;

    logic        clk, reset;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_mem_req_o;
    logic [31:0] fetch_mem_addr_o;
    logic        fetch_mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rd_inst_i;
    logic        inst_valid_o;
    logic [31:0] inst_o, inst_pc_o;
    logic        inst_ready_i;

    rsv_fetch_buf #(
        .DEPTH     (DEPTH),
        .MAX_OUTST (MAX_OUTST),
        .RESET_PC  (RST_PC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .fetch_mem_req_o  (fetch_mem_req_o),
        .fetch_mem_addr_o (fetch_mem_addr_o),
        .fetch_mem_gnt_i  (fetch_mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rd_inst_i    (mem_rd_inst_i),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_ready_i     (inst_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]  m_pc;
    logic [31:0]  m_pend[$];   // granted addresses awaiting a kept response
    int           m_drop;      // responses to discard
    fetch_entry_t m_buf[$];    // instruction buffer contents
    logic [31:0]  mem_q[$];    // memory side: every granted, unreturned address
    logic [31:0]  g_log[$];    // observed granted addresses
    logic [31:0]  c_log[$];    // observed consumed instruction addresses

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic bit m_req();
        return !redirect_i
            && (m_pend.size() + m_drop < MAX_OUTST)
            && (m_buf.size() + m_pend.size() < DEPTH);
    endfunction

    task automatic model_reset();
        m_pc   = RST_PC;
        m_drop = 0;
        m_pend.delete();
        m_buf.delete();
        mem_q.delete();
    endtask

    task automatic drive(input bit rd, input logic [31:0] rpc, input bit g,
                         input bit rv, input bit rdy);
        @(negedge clk);
        redirect_i      = rd;
        redirect_pc_i   = rpc;
        fetch_mem_gnt_i = g;
        inst_ready_i    = rdy;
        mem_rvalid_i    = rv && (mem_q.size() > 0);
        mem_rd_inst_i   = mem_rvalid_i ? mem_word(mem_q[0]) : $urandom();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_req"},   32'(fetch_mem_req_o), 32'(m_req()));
        check({tag, "_addr"},  fetch_mem_addr_o, m_pc);
        check({tag, "_valid"}, 32'(inst_valid_o), 32'(m_buf.size() > 0));
        if (m_buf.size() > 0) begin
            check({tag, "_inst"}, inst_o, m_buf[0].inst);
            check({tag, "_pc"},   inst_pc_o, m_buf[0].pc);
        end
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic tick();
        bit          req, rv, acc, dropped;
        logic [31:0] data, a;
        req  = m_req();
        rv   = mem_rvalid_i;
        data = mem_rd_inst_i;
        if (fetch_mem_req_o && fetch_mem_gnt_i) g_log.push_back(fetch_mem_addr_o);
        if (inst_valid_o && inst_ready_i) c_log.push_back(inst_pc_o);
        if (rv) void'(mem_q.pop_front());
        if (req && fetch_mem_gnt_i) mem_q.push_back(m_pc);
        if (redirect_i) begin
            dropped = rv && (m_drop > 0);
            acc     = rv && (m_drop == 0) && (m_pend.size() > 0);
            m_drop  = m_drop - int'(dropped) + m_pend.size() - int'(acc);
            m_pend.delete();
            m_buf.delete();
            m_pc = redirect_pc_i & 32'hFFFF_FFFC;
        end else begin
            if (m_buf.size() > 0 && inst_ready_i) void'(m_buf.pop_front());
            if (rv) begin
                if (m_drop > 0) m_drop--;
                else if (m_pend.size() > 0) begin
                    a = m_pend.pop_front();
                    m_buf.push_back('{pc: a, inst: data});
                end
            end
            if (req && fetch_mem_gnt_i) begin
                m_pend.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
    endtask

    task automatic step(input string tag, input bit rd, input logic [31:0] rpc,
                        input bit g, input bit rv, input bit rdy);
        drive(rd, rpc, g, rv, rdy);
        check_model(tag);
        tick();
    endtask

    // Asynchronous reset mid-cycle, outputs checked before any clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check({tag, "_rst_req"},   32'(fetch_mem_req_o), 32'd0);
        check({tag, "_rst_addr"},  fetch_mem_addr_o, RST_PC);
        check({tag, "_rst_valid"}, 32'(inst_valid_o), 32'd0);
        check({tag, "_rst_inst"},  inst_o, 32'd0);
        check({tag, "_rst_pc"},    inst_pc_o, 32'd0);
        redirect_i      = 1'b0;
        redirect_pc_i   = '0;
        fetch_mem_gnt_i = 1'b0;
        mem_rvalid_i    = 1'b0;
        mem_rd_inst_i   = '0;
        inst_ready_i    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check({tag, "_first_req"},  32'(fetch_mem_req_o), 32'd1);
        check({tag, "_first_addr"}, fetch_mem_addr_o, RST_PC);
    endtask

    typedef struct {
        bit          gnt, rv, rdy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    vec_t tbl[5];

    initial begin
        bit found;
        reset           = 1'b1;
        redirect_i      = 1'b0;
        redirect_pc_i   = '0;
        fetch_mem_gnt_i = 1'b0;
        mem_rvalid_i    = 1'b0;
        mem_rd_inst_i   = '0;
        inst_ready_i    = 1'b0;
        model_reset();

        // Streaming: grant every cycle, data one cycle later, always ready.
        tbl[0] = '{gnt:1, rv:0, rdy:1, e_req:1, e_addr:32'h0,  e_valid:0, e_pc:32'h0, e_inst:32'h0};
        tbl[1] = '{gnt:1, rv:1, rdy:1, e_req:1, e_addr:32'h4,  e_valid:0, e_pc:32'h0, e_inst:32'h0};
        tbl[2] = '{gnt:1, rv:1, rdy:1, e_req:1, e_addr:32'h8,  e_valid:1, e_pc:32'h0, e_inst:32'hC0DE_0000};
        tbl[3] = '{gnt:1, rv:1, rdy:1, e_req:1, e_addr:32'hC,  e_valid:1, e_pc:32'h4, e_inst:32'hC0DE_0004};
        tbl[4] = '{gnt:1, rv:1, rdy:1, e_req:1, e_addr:32'h10, e_valid:1, e_pc:32'h8, e_inst:32'hC0DE_0008};

        do_reset("por");
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, tbl[i].gnt, tbl[i].rv, tbl[i].rdy);
            check($sformatf("tbl%0d_req", i),   32'(fetch_mem_req_o), 32'(tbl[i].e_req));
            check($sformatf("tbl%0d_addr", i),  fetch_mem_addr_o, tbl[i].e_addr);
            check($sformatf("tbl%0d_valid", i), 32'(inst_valid_o), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                check($sformatf("tbl%0d_pc", i),   inst_pc_o, tbl[i].e_pc);
                check($sformatf("tbl%0d_inst", i), inst_o, tbl[i].e_inst);
            end
            tick();
        end

        // Back-pressure: consumer stalled, credits must stop after 4 grants.
        do_reset("fill");
        g_log.delete();
        for (int i = 0; i < 10; i++) step("fill", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("fill_grants", 32'(g_log.size()), 32'd4);
        g_log.delete();
        c_log.delete();
        for (int i = 0; i < 12; i++) step("drain", 1'b0, '0, 1'b1, 1'b1, 1'b1);
        check("resume_grant_seen", 32'(g_log.size() > 0), 32'd1);
        if (g_log.size() > 0) check("resume_addr", g_log[0], 32'h10);
        check("resume_consumed", 32'(c_log.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < c_log.size(); i++)
            check($sformatf("resume_pc%0d", i), c_log[i], 32'(i * 4));

        // Redirect with two requests outstanding and one entry buffered.
        do_reset("redir");
        step("redir", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("redir", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        step("redir", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("redir", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
        check("redir_flush_valid", 32'(inst_valid_o), 32'd0);
        check("redir_gate_req", 32'(fetch_mem_req_o), 32'd0);
        check_model("redir_after");
        tick();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
            check_model("redir_run");
            if (inst_valid_o) begin
                found = 1'b1;
                check("redir_first_pc", inst_pc_o, 32'h100);
            end
            tick();
        end
        check("redir_valid_seen", 32'(found), 32'd1);

        // Stalled grant: request held, redirect is the only withdrawal.
        do_reset("stall");
        for (int i = 0; i < 5; i++) begin
            drive(i == 2, 32'h203, 1'b0, 1'b0, 1'b1);
            check_model("stall");
            if (i < 2) begin
                check($sformatf("stall%0d_req", i),  32'(fetch_mem_req_o), 32'd1);
                check($sformatf("stall%0d_addr", i), fetch_mem_addr_o, 32'h0);
            end else if (i == 2) begin
                check("stall_redir_req", 32'(fetch_mem_req_o), 32'd0);
            end else begin
                check($sformatf("stall%0d_req", i),  32'(fetch_mem_req_o), 32'd1);
                check($sformatf("stall%0d_addr", i), fetch_mem_addr_o, 32'h200);
            end
            tick();
        end

        // Address wrap at the top of the address space.
        step("wrap", 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b1);
        g_log.delete();
        for (int i = 0; i < 8; i++) step("wrap", 1'b0, '0, 1'b1, 1'b1, 1'b1);
        check("wrap_grants", 32'(g_log.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < g_log.size(); i++)
            check($sformatf("wrap_addr%0d", i), g_log[i], 32'hFFFF_FFF8 + 32'(i * 4));

        // Reset while two entries are buffered and two requests outstanding.
        do_reset("busy");
        step("busy", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("busy", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        step("busy", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        step("busy", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("busy_buffered", 32'(m_buf.size()), 32'd2);
        check("busy_valid", 32'(inst_valid_o), 32'd1);
        do_reset("busy");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step("rand", $urandom_range(15) == 0, $urandom(),
                 $urandom_range(3) != 0, $urandom_range(9) < 6,
                 $urandom_range(9) < 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
